pwm_multichannel: RTL
=====================

# pwm_multichannel

Parametrised multi-channel PWM generator, successor to the single-channel 8-bit dynamic PWM. It drives CHANNELS outputs from one shared period counter with configurable resolution and a clock prescaler. It adds edge-aligned and center-aligned modes, and double-buffered duty registers that update glitch-free at the period boundary. It sits between a register/control interface and the output pins, such as LEDs or motor drivers.

## Interface
- CHANNELS, 4, number of PWM outputs (1..16)
- WIDTH, 8, duty/counter resolution in bits (2..16); MAX = 2^WIDTH - 1
- PRESCALE_WIDTH, 8, width of the prescale input
- SEL_WIDTH, $clog2(CHANNELS) (min 1), width of duty_sel

- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = run; 0 = hold counter, outputs low
- prescale  in  PRESCALE_WIDTH  counter advances once every prescale+1 clocks
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned
- duty_wr  in  1  one-clock write strobe for a shadow duty register
- duty_sel  in  SEL_WIDTH  channel index for duty_wr
- duty_data  in  WIDTH  duty value written to shadow[duty_sel]
- pwm  out  CHANNELS  registered PWM outputs, bit i = channel i
- period_end  out  1  one-clock pulse at each period boundary

## Operation
- Reset (reset=1 at a clock edge) clears all state:
  - pre_cnt=0, cnt=0, dir=up, mode_active=edge
  - all shadow and active duties = 0
  - pwm=0, period_end=0
  - reset overrides every other input, including mid-period.
- Prescaler: tick=1 when pre_cnt >= prescale, and pre_cnt then returns to 0; otherwise pre_cnt increments.
  - Using >= means a lowered prescale takes effect on the next clock.
  - The counter only moves on tick cycles.
- Edge mode: cnt counts 0..MAX-1 then wraps to 0.
  - Period = MAX ticks.
  - The wrap tick is the boundary.
- Center mode: cnt visits 0,1,…,MAX-1 with dir=up, then MAX-1,…,0 with dir=down.
  - Each value is held one tick in each direction, so the turnaround repeats the end value.
  - Period = 2*MAX ticks.
  - The boundary is the tick leaving (cnt=0, dir=down).
- Compare: channel i is high while cnt < duty_active[i].
  - duty=0 gives 0%; duty=MAX gives 100%.
  - Center mode high time = 2*duty ticks, symmetric about the boundary.
- Double buffering:
  - duty_wr writes shadow[duty_sel] on the strobe clock.
  - duty_sel >= CHANNELS: the write is ignored.
  - On a boundary tick, every duty_active copies its shadow, and mode_active copies center_mode.
  - A write on the same clock as a boundary lands in shadow only; it takes effect at the following boundary.
- Disabled (enable=0):
  - pre_cnt=0, cnt=0, dir=up, pwm=0, period_end=0.
  - duty_active and mode_active follow shadow/center_mode every clock.
  - Shadow writes are still accepted.
- Re-enable: the first period starts at cnt=0 with the latest shadow values. No period_end is issued for this start.

## Timing
- pwm is registered: pwm[i] on cycle n+1 reflects (cnt < duty_active[i]) on cycle n, i.e. one clock latency.
- period_end is high for exactly one clock. That clock is the first one in which pwm reflects the new period's cnt=0 and new duties.
- Period in clocks:
  - edge mode: (prescale+1)*MAX
  - center mode: 2*(prescale+1)*MAX
- After reset deasserts with enable=1, the first pwm rise occurs 2 clocks later, provided a nonzero duty was loaded while disabled.
- A prescale change mid-count never produces a tick interval longer than max(old, new)+1 clocks.
- A center_mode change mid-period has no effect until the next boundary.

## Test plan
- Reset and disable:
  - Stimulus: reset=1 for 3 clocks, then enable=0 for 100 clocks with duty 128 written to all channels.
  - Required: pwm=0 and period_end=0 throughout; no pulse on re-enable.
- Edge mode, WIDTH=8, prescale=0:
  - Stimulus: duties 0, 59, 128, 255 on ch0..3.
  - Required: per 255-clock period, high counts are 0, 59, 128, 255; period_end every 255 clocks.
- Shadow update:
  - Stimulus: ch1 at 128; write 64 mid-period.
  - Required: the current period stays 128 high and the next is 64.
  - Stimulus: a write of 10 coincident with period_end's boundary edge.
  - Required: 10 appears one period later.
- Center mode:
  - Stimulus: duty 64.
  - Required: per 510-clock period, 64 high, 382 low, 64 high, with period_end at the middle of the high pulse.
  - Stimulus: duty 255.
  - Required: constantly high.
- Prescaler:
  - Stimulus: prescale=3, duty 128.
  - Required: period 1020 clocks, 512 high.
  - Stimulus: prescale changed 9→2 while pre_cnt=5.
  - Required: tick on the next clock, then every 3 clocks.
- Robustness:
  - Stimulus: duty_sel=CHANNELS write.
  - Required: no channel changes.
  - Stimulus: reset mid-period.
  - Required: outputs 0 on the next clock and all duties cleared.

Source files
------------

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: one shared prescaled period counter, edge- or
// center-aligned compare, and shadow/active duty pairs swapped at period boundaries.
module pwm_multichannel #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 8,
  parameter int SEL_WIDTH      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      center_mode,
  input  logic                      duty_wr,
  input  logic [SEL_WIDTH-1:0]      duty_sel,
  input  logic [WIDTH-1:0]          duty_data,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_end
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  typedef enum logic {MODE_EDGE, MODE_CENTER} mode_t;

  // Highest value cnt ever reaches (MAX-1); keeps duty=MAX fully on.
  localparam logic [WIDTH-1:0]   TOP      = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [SEL_WIDTH:0] CH_LIMIT = (SEL_WIDTH+1)'(CHANNELS);

  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [WIDTH-1:0]          cnt;
  dir_t                      dir;
  mode_t                     mode_active;
  logic [WIDTH-1:0]          shadow      [CHANNELS];
  logic [WIDTH-1:0]          duty_active [CHANNELS];
  logic                      boundary_q;

  logic                      tick;
  logic                      boundary;
  logic                      wr_hit;
  logic [WIDTH-1:0]          cnt_next;
  dir_t                      dir_next;
  logic [CHANNELS-1:0]       compare;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tick     = (pre_cnt >= prescale);
    cnt_next = cnt;
    dir_next = dir;
    boundary = 1'b0;
    if (tick) begin
      if (mode_active == MODE_EDGE) begin
        dir_next = DIR_UP;
        if (cnt >= TOP) begin
          cnt_next = '0;
          boundary = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end else if (dir == DIR_UP) begin
        // The turnaround holds TOP for a second tick on the way down.
        if (cnt >= TOP) dir_next = DIR_DOWN;
        else            cnt_next = cnt + 1'b1;
      end else if (cnt == '0) begin
        dir_next = DIR_UP;
        boundary = 1'b1;
      end else begin
        cnt_next = cnt - 1'b1;
      end
    end
  end

  always_comb begin
    compare = '0;
    for (int i = 0; i < CHANNELS; i++) compare[i] = (cnt < duty_active[i]);
  end

  assign wr_hit = duty_wr && ({1'b0, duty_sel} < CH_LIMIT);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and the boundary swap sees the old shadow contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      dir         <= DIR_UP;
      mode_active <= MODE_EDGE;
      boundary_q  <= 1'b0;
      period_end  <= 1'b0;
      pwm         <= '0;
      // NOTE: these duty arrays are a handful of flops whose cleared state is
      // observable behaviour, so unlike a RAM they are reset explicitly.
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i]      <= '0;
        duty_active[i] <= '0;
      end
    end else begin
      if (wr_hit) shadow[duty_sel] <= duty_data;

      if (!enable) begin
        pre_cnt     <= '0;
        cnt         <= '0;
        dir         <= DIR_UP;
        boundary_q  <= 1'b0;
        period_end  <= 1'b0;
        pwm         <= '0;
        mode_active <= mode_t'(center_mode);
        for (int i = 0; i < CHANNELS; i++) duty_active[i] <= shadow[i];
      end else begin
        pre_cnt    <= tick ? '0 : pre_cnt + 1'b1;
        cnt        <= cnt_next;
        dir        <= dir_next;
        pwm        <= compare;
        // Two stages: the pulse lines up with the first pwm sample of the new period.
        boundary_q <= boundary;
        period_end <= boundary_q;
        if (boundary) begin
          mode_active <= mode_t'(center_mode);
          for (int i = 0; i < CHANNELS; i++) duty_active[i] <= shadow[i];
        end
      end
    end
  end

endmodule
